// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, flag-vector layout and a flag packing helper.
package alu_pkg;

  localparam int OP_W   = 4;
  localparam int FLAG_W = 4;

  localparam int FLAG_CARRY = 3;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_NEG   = 0;

  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_AND  = 4'h2;
  localparam logic [OP_W-1:0] OP_OR   = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h4;
  localparam logic [OP_W-1:0] OP_SLL  = 4'h5;
  localparam logic [OP_W-1:0] OP_SRL  = 4'h6;
  localparam logic [OP_W-1:0] OP_SRA  = 4'h7;
  localparam logic [OP_W-1:0] OP_SLT  = 4'h8;
  localparam logic [OP_W-1:0] OP_SLTU = 4'h9;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic c, input logic o,
                                                   input logic z, input logic n);
    logic [FLAG_W-1:0] f;
    f             = '0;
    f[FLAG_CARRY] = c;
    f[FLAG_OVF]   = o;
    f[FLAG_ZERO]  = z;
    f[FLAG_NEG]   = n;
    return f;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// ALU-to-result-stage and result-stage-to-consumer handshake bundle.
// master drives the ALU side and the consumer ready; slave is the result stage.
interface alu_result_stage_if #(parameter int WIDTH = 32) ();
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_y;
  logic              in_carry;
  logic              in_overflow;
  logic              in_zero;
  logic              in_negative;
  logic [OP_W-1:0]   in_op;

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_y;
  logic [FLAG_W-1:0] out_flags;
  logic [OP_W-1:0]   out_op;

  modport master (
    output in_valid, in_y, in_carry, in_overflow, in_zero, in_negative, in_op, out_ready,
    input  in_ready, out_valid, out_y, out_flags, out_op
  );

  modport slave (
    input  in_valid, in_y, in_carry, in_overflow, in_zero, in_negative, in_op, out_ready,
    output in_ready, out_valid, out_y, out_flags, out_op
  );

endinterface

// File: rtl/alu_skid_buf.sv
// Generic 2-entry skid buffer: 1-cycle latency, full throughput; in_rdy comes
// straight from a flop so upstream never sees a combinational path from out_rdy.
module alu_skid_buf #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic         m_vld_q, m_vld_d;
  logic [W-1:0] m_dat_q, m_dat_d;
  logic         s_vld_q, s_vld_d;
  logic [W-1:0] s_dat_q, s_dat_d;
  logic         in_rdy_q, in_rdy_d;
  logic         accept;
  logic         consume;

  assign accept  = in_vld & in_rdy_q;
  assign consume = m_vld_q & out_rdy;

  always_comb begin
    m_vld_d = m_vld_q;
    m_dat_d = m_dat_q;
    s_vld_d = s_vld_q;
    s_dat_d = s_dat_q;
    if (consume) begin
      // accept is impossible while S is valid, so S draining never races a load
      if (s_vld_q) begin
        m_dat_d = s_dat_q;
        s_vld_d = 1'b0;
      end else if (accept) begin
        m_dat_d = in_dat;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!m_vld_q) begin
        m_vld_d = 1'b1;
        m_dat_d = in_dat;
      end else begin
        s_vld_d = 1'b1;
        s_dat_d = in_dat;
      end
    end
    in_rdy_d = !s_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld_q  <= 1'b0;
      m_dat_q  <= '0;
      s_vld_q  <= 1'b0;
      s_dat_q  <= '0;
      in_rdy_q <= 1'b1;
    end else begin
      m_vld_q  <= m_vld_d;
      m_dat_q  <= m_dat_d;
      s_vld_q  <= s_vld_d;
      s_dat_q  <= s_dat_d;
      in_rdy_q <= in_rdy_d;
    end
  end

  assign in_rdy  = in_rdy_q;
  assign out_vld = m_vld_q;
  assign out_dat = m_dat_q;

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage with sticky carry/overflow and an accept counter.
// 1-cycle latency when empty; absorbs one extra result under backpressure, then drops in_ready.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_result_stage_if.slave bus,
  input  logic             clr_sticky,
  output logic             sticky_carry,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] result_count
);

  localparam int PAY_W = WIDTH + FLAG_W + OP_W;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] out_pay;
  logic             accept;

  logic             sticky_carry_q, sticky_carry_d;
  logic             sticky_ovf_q, sticky_ovf_d;
  logic [CNT_W-1:0] result_count_q, result_count_d;

  assign in_pay = {bus.in_y,
                   pack_flags(bus.in_carry, bus.in_overflow, bus.in_zero, bus.in_negative),
                   bus.in_op};

  alu_skid_buf #(.W(PAY_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (bus.in_valid),
    .in_rdy  (bus.in_ready),
    .in_dat  (in_pay),
    .out_vld (bus.out_valid),
    .out_rdy (bus.out_ready),
    .out_dat (out_pay)
  );

  assign bus.out_y     = out_pay[PAY_W-1 -: WIDTH];
  assign bus.out_flags = out_pay[OP_W +: FLAG_W];
  assign bus.out_op    = out_pay[OP_W-1:0];

  assign accept = bus.in_valid & bus.in_ready;

  always_comb begin
    sticky_carry_d = clr_sticky ? 1'b0 : sticky_carry_q;
    sticky_ovf_d   = clr_sticky ? 1'b0 : sticky_ovf_q;
    result_count_d = result_count_q;
    // a setting acceptance overrides a simultaneous clear
    if (accept) begin
      sticky_carry_d = sticky_carry_d | bus.in_carry;
      sticky_ovf_d   = sticky_ovf_d | bus.in_overflow;
      result_count_d = result_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_carry_q <= 1'b0;
      sticky_ovf_q   <= 1'b0;
      result_count_q <= '0;
    end else begin
      sticky_carry_q <= sticky_carry_d;
      sticky_ovf_q   <= sticky_ovf_d;
      result_count_q <= result_count_d;
    end
  end

  assign sticky_carry = sticky_carry_q;
  assign sticky_ovf   = sticky_ovf_q;
  assign result_count = result_count_q;

endmodule
